// File: rtl/exibe_sequencia.sv
// exibe_sequencia: reads items 0..limite from a synchronous 16x4 ROM and shows
// each on the leds for T_ACESO cycles, followed by T_APAGADO dark cycles.
// A one-cycle pronto pulse marks the end of the sequence.
module exibe_sequencia #(
    parameter int unsigned T_ACESO   = 4,
    parameter int unsigned T_APAGADO = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    // 27 bits hold 2^26 with no overflow.
    localparam int unsigned TimerW = 27;
    // Timer counts 0..T-1 inside a phase, so the last cycle is T-1.
    localparam logic [TimerW-1:0] AcesoFim   = TimerW'(T_ACESO - 1);
    localparam logic [TimerW-1:0] ApagadoFim = TimerW'(T_APAGADO - 1);

    typedef enum logic [3:0] {
        StInicial = 4'd0,
        StPrepara = 4'd1,
        StBusca   = 4'd2,
        StAcende  = 4'd3,
        StApaga   = 4'd4,
        StFim     = 4'd5
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [3:0]        endereco_q, endereco_d;
    logic [3:0]        leds_q, leds_d;
    logic [3:0]        limite_q, limite_d;
    logic [TimerW-1:0] timer_q, timer_d;

    // State and datapath registers; asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= StInicial;
            endereco_q <= 4'd0;
            leds_q     <= 4'd0;
            limite_q   <= 4'd0;
            timer_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            leds_q     <= leds_d;
            limite_q   <= limite_d;
            timer_q    <= timer_d;
        end
    end

    // Next-state and datapath update; everything holds unless a state says otherwise.
    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        leds_d     = leds_q;
        limite_d   = limite_q;
        timer_d    = timer_q;

        case (estado_q)
            StInicial: begin
                leds_d = 4'd0;
                if (iniciar) begin
                    limite_d   = limite;
                    endereco_d = 4'd0;
                    timer_d    = '0;
                    estado_d   = StPrepara;
                end
            end
            // ROM sees endereco this cycle; data is valid during StBusca.
            StPrepara: begin
                estado_d = StBusca;
            end
            StBusca: begin
                leds_d   = dado;
                timer_d  = '0;
                estado_d = StAcende;
            end
            StAcende: begin
                if (timer_q == AcesoFim) begin
                    leds_d   = 4'd0;
                    timer_d  = '0;
                    estado_d = StApaga;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StApaga: begin
                if (timer_q == ApagadoFim) begin
                    timer_d = '0;
                    // Stop on the last index instead of incrementing, so 15 never wraps.
                    if (endereco_q == limite_q) begin
                        estado_d = StFim;
                    end else begin
                        endereco_d = endereco_q + 4'd1;
                        estado_d   = StPrepara;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StFim: begin
                leds_d   = 4'd0;
                estado_d = StInicial;
            end
            default: begin
                leds_d   = 4'd0;
                timer_d  = '0;
                estado_d = StInicial;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        endereco  = endereco_q;
        leds      = leds_q;
        ocupado   = (estado_q != StInicial);
        pronto    = (estado_q == StFim);
        db_estado = estado_q;
    end

endmodule

// File: tb/tb_exibe_sequencia.sv
// Scoreboard bench for exibe_sequencia: a driver pushes the expected outputs
// for every cycle it drives; a monitor pops and compares on each falling edge.
module tb_exibe_sequencia;

    localparam int unsigned TA   = 4;
    localparam int unsigned TP   = 2;
    localparam int unsigned ITEM = 2 + TA + TP;

    typedef struct packed {
        logic [3:0] leds;
        logic [3:0] endereco;
        logic [3:0] db;
        logic       ocupado;
        logic       pronto;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] limite = 4'd0;
    logic [3:0] dado = 4'd0;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] rom [16];
    exp_t       exp_q[$];
    logic [3:0] last_end = 4'd0;
    int         n_vec = 0;
    int         n_fail = 0;
    int         cyc = 0;

    exibe_sequencia #(
        .T_ACESO  (TA),
        .T_APAGADO(TP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .limite   (limite),
        .dado     (dado),
        .endereco (endereco),
        .leds     (leds),
        .ocupado  (ocupado),
        .pronto   (pronto),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: data valid one clock after the address.
    always @(posedge clock) dado <= rom[endereco];

    function automatic exp_t mk(input logic [3:0] l, input logic [3:0] e, input logic [3:0] d,
                                input logic o, input logic p);
        exp_t r;
        r.leds = l; r.endereco = e; r.db = d; r.ocupado = o; r.pronto = p;
        return r;
    endfunction

    // Monitor: compares the DUT outputs with the next expected entry.
    always @(negedge clock) begin
        exp_t e;
        exp_t got;
        cyc <= cyc + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {leds, endereco, db_estado, ocupado, pronto};
            n_vec = n_vec + 1;
            if (got !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL cycle %0d: got leds=%h end=%h st=%h oc=%b pr=%b, want leds=%h end=%h st=%h oc=%b pr=%b",
                         cyc, got.leds, got.endereco, got.db, got.ocupado, got.pronto,
                         e.leds, e.endereco, e.db, e.ocupado, e.pronto);
            end
        end
    end

    task automatic step(input logic r, input logic ini, input logic [3:0] lim, input exp_t e);
        @(posedge clock);
        #1;
        reset   = r;
        iniciar = ini;
        limite  = lim;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 4'($urandom), mk(4'd0, last_end, 4'd0, 1'b0, 1'b0));
    endtask

    // noise: 0 quiet inputs while busy, 1 random iniciar/limite, 2 iniciar held high.
    // abort_at: trace index at which reset is pulled low (-1 for none).
    task automatic run_seq(input logic [3:0] lim, input int noise, input int abort_at);
        exp_t       tr[$];
        logic [3:0] snap [16];
        logic       ini;
        logic [3:0] l;
        snap = rom;
        tr.push_back(mk(4'd0, last_end, 4'd0, 1'b0, 1'b0));
        for (int a = 0; a <= int'(lim); a++) begin
            tr.push_back(mk(4'd0, 4'(a), 4'd1, 1'b1, 1'b0));
            tr.push_back(mk(4'd0, 4'(a), 4'd2, 1'b1, 1'b0));
            for (int k = 0; k < int'(TA); k++) tr.push_back(mk(snap[a], 4'(a), 4'd3, 1'b1, 1'b0));
            for (int k = 0; k < int'(TP); k++) tr.push_back(mk(4'd0, 4'(a), 4'd4, 1'b1, 1'b0));
        end
        tr.push_back(mk(4'd0, lim, 4'd5, 1'b1, 1'b1));
        for (int i = 0; i < tr.size(); i++) begin
            if (i == abort_at) begin
                step(1'b0, 1'b0, lim, mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
                step(1'b0, 1'b1, lim, mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
                last_end = 4'd0;
                step(1'b1, 1'b0, lim, mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
                idle(2);
                return;
            end
            if (i == 0) begin
                ini = 1'b1; l = lim;
            end else if (noise == 1) begin
                ini = 1'($urandom); l = 4'($urandom);
            end else if (noise == 2) begin
                ini = 1'b1; l = 4'($urandom);
            end else begin
                ini = 1'b0; l = lim;
            end
            step(1'b1, ini, l, tr[i]);
        end
        last_end = lim;
        idle(1 + int'($urandom_range(0, 2)));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));
        // Reset state and staying idle without iniciar.
        step(1'b0, 1'b1, 4'd7, mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 4'd7, mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        step(1'b1, 1'b0, 4'd7, mk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        idle(3);

        run_seq(4'd2, 0, -1);                    // leds 1,2,4; pronto 24 cycles after accept
        run_seq(4'd0, 0, -1);                    // single item
        run_seq(4'd15, 0, -1);                   // full ROM, no wrap
        run_seq(4'd2, 2, -1);                    // iniciar/limite noise while busy
        run_seq(4'd3, 0, 1 + int'(ITEM) + 2 + int'(TA)); // reset in APAGA of item 1
        run_seq(4'd1, 0, -1);                    // restarts from address 0 after reset
        rom[1] = 4'd0;
        run_seq(4'd1, 0, -1);                    // zero item still lit phase of full length

        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);
            run_seq(4'($urandom), 1, ((n % 4) == 3) ? int'($urandom_range(2, 20)) : -1);
        end

        @(negedge clock);
        @(negedge clock);
        #1;
        n_vec = n_vec + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/exibe_sequencia.md
EXIBE_SEQUENCIA -- requirements
Module: exibe_sequencia

Interface
REQ-001 The block SHALL have parameter T_ACESO, default 4, meaning clock cycles each sequence item is shown on leds (legal 1..2^26).
REQ-002 The block SHALL have parameter T_APAGADO, default 2, meaning clock cycles leds stay dark between items (legal 1..2^26).
REQ-003 The block SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port iniciar, input, 1 bit: start request, sampled only in state INICIAL.
REQ-006 The block SHALL have port limite, input, 4 bits: index of last item to show, latched when start is accepted.
REQ-007 The block SHALL have port dado, input, 4 bits: read data from the team's 16x4 synchronous ROM, valid one clock after endereco.
REQ-008 The block SHALL have port endereco, output, 4 bits: ROM address.
REQ-009 The block SHALL have port leds, output, 4 bits: displayed item; registered.
REQ-010 The block SHALL have port ocupado, output, 1 bit: high in every state except INICIAL.
REQ-011 The block SHALL have port pronto, output, 1 bit: one-cycle pulse when the sequence completes.
REQ-012 The block SHALL have port db_estado, output, 4 bits: state code, INICIAL=0 PREPARA=1 BUSCA=2 ACENDE=3 APAGA=4 FIM=5.

Function
REQ-013 The FSM SHALL have states INICIAL, PREPARA, BUSCA, ACENDE, APAGA, FIM and no others; unused codes SHALL go to INICIAL.
REQ-014 INICIAL: leds=0, ocupado=0, pronto=0; iniciar=1 SHALL latch limite into limite_reg, set endereco=0 and go to PREPARA.
REQ-015 PREPARA SHALL last exactly one cycle with endereco stable, then go to BUSCA.
REQ-016 BUSCA SHALL last exactly one cycle, load dado into the leds register at its end, clear the timer and go to ACENDE.
REQ-017 ACENDE SHALL hold leds at the captured value for exactly T_ACESO cycles, then go to APAGA with leds=0.
REQ-018 APAGA SHALL hold leds=0 for exactly T_APAGADO cycles; at exit, endereco==limite_reg SHALL go to FIM, else endereco SHALL increment by 1 and go to PREPARA.
REQ-019 FIM SHALL last one cycle with pronto=1, ocupado=1, leds=0, then return to INICIAL.
REQ-020 Each item SHALL occupy exactly 2+T_ACESO+T_APAGADO cycles; the first lit cycle SHALL be the third cycle after the cycle iniciar is accepted.
REQ-021 iniciar SHALL be ignored in all states other than INICIAL; changes on limite after acceptance SHALL have no effect.
REQ-022 endereco SHALL never wrap: limite=15 shows items 0..15 and stops; limite=0 shows item 0 only.
REQ-023 An item value of 0 SHALL still consume its full ACENDE time (leds=0 throughout).
REQ-024 The timer SHALL be wide enough for 2^26 with no overflow; comparisons SHALL be unsigned.

Reset
REQ-025 reset=0 SHALL, asynchronously and regardless of state, force INICIAL, endereco=0, leds=0, limite_reg=0, timer=0, ocupado=0, pronto=0, db_estado=0.
REQ-026 After reset deasserts, the block SHALL remain in INICIAL until iniciar=1 is sampled; a reset mid-sequence SHALL not produce a pronto pulse.

Verification
REQ-027 Bench ROM model {0:1,1:2,2:4,...}, defaults, limite=2, iniciar pulse -> leds 1,2,4 each for 4 cycles separated by 2 dark cycles; pronto high exactly 1 cycle, 24 cycles after acceptance.
REQ-028 limite=0 -> only item 0 shown; pronto 8 cycles after acceptance; endereco stays 0.
REQ-029 limite=15 -> 16 items shown in address order 0..15; pronto after 128 cycles; endereco ends at 15, no wrap to 0.
REQ-030 iniciar pulsed again and limite changed during ACENDE of item 1 -> no restart; sequence length unchanged.
REQ-031 reset=0 asserted during APAGA of item 1 -> immediately leds=0, ocupado=0, db_estado=0; no pronto; next iniciar restarts from endereco 0.
REQ-032 ROM item equal to 0 at address 1, limite=1 -> leds 0 for 4 cycles at item 1 while ocupado=1, db_estado=3.
